// File: rtl/serial_io_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_io_master
// Description : Serial-to-IO-bus bridge. Parses command frames from the serial
//               receive path, runs one transaction on the 32-bit IO strobe bus
//               and sends a reply on the serial transmit path.
//               Frames : 'W' A3 A2 A1 A0 D3 D2 D1 D0  /  'R' A3 A2 A1 A0
//               Replies: 'K' | 'D' d3 d2 d1 d0 | 'T' (bus timeout) | '?'
// Ports       : clk, rst_n (async, active-low)
//               rx_data/new_rx_data       serial receive byte + valid pulse
//               tx_data/new_tx_data/tx_busy serial transmit byte/pulse/busy
//               io_*_strobe, io_address, io_write_data, io_byte_enable,
//               io_read_data, io_ready    IO bus initiator side
//               busy                      transaction or reply in progress
//               drop_count                saturating count of dropped rx bytes
// Revision    : 1.0 - initial release
// ============================================================================
module serial_io_master #(
    parameter int IO_TIMEOUT    = 1024,
    parameter int FRAME_TIMEOUT = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    output logic        io_addr_strobe,
    output logic        io_read_strobe,
    output logic        io_write_strobe,
    output logic [31:0] io_address,
    output logic [31:0] io_write_data,
    output logic [3:0]  io_byte_enable,
    input  logic [31:0] io_read_data,
    input  logic        io_ready,
    output logic        busy,
    output logic [7:0]  drop_count
);

    localparam int IO_TW = $clog2(IO_TIMEOUT + 1);
    localparam int FR_TW = $clog2(FRAME_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [7:0] c_OP_WRITE    = 8'h57;
    localparam logic [7:0] c_OP_READ     = 8'h52;
    localparam logic [7:0] c_RSP_OK      = 8'h4B;
    localparam logic [7:0] c_RSP_DATA    = 8'h44;
    localparam logic [7:0] c_RSP_TIMEOUT = 8'h54;
    localparam logic [7:0] c_RSP_BAD     = 8'h3F;

    logic [2:0]       state_q, state_d;
    logic             is_write_q;
    logic [1:0]       byte_cnt_q;
    logic [31:0]      addr_sh_q;
    logic [23:0]      wdata_sh_q;
    logic [31:0]      io_address_q;
    logic [31:0]      io_write_data_q;
    logic [IO_TW-1:0] io_timer_q;
    logic [FR_TW-1:0] frame_timer_q;
    logic [39:0]      resp_q;       // reply bytes, next byte to send in [39:32]
    logic [2:0]       resp_cnt_q;   // reply bytes still to send
    logic             guard_q;      // cycle after a tx pulse: tx_busy not trusted yet
    logic [7:0]       drop_q;

    logic w_op_known;
    logic w_last_addr;
    logic w_last_data;
    logic w_frame_expired;
    logic w_io_expired;
    logic w_send;
    logic w_in_frame;

    assign w_op_known   = (rx_data == c_OP_WRITE) || (rx_data == c_OP_READ);
    assign w_in_frame   = (state_q == S_ADDR) || (state_q == S_DATA);
    assign w_last_addr  = (state_q == S_ADDR) && new_rx_data && (byte_cnt_q == 2'd3);
    assign w_last_data  = (state_q == S_DATA) && new_rx_data && (byte_cnt_q == 2'd3);
    // Timer holds the number of idle cycles already seen, so expiry is the
    // FRAME_TIMEOUT-th idle cycle without a byte.
    assign w_frame_expired = w_in_frame && !new_rx_data &&
                             (frame_timer_q == FR_TW'(FRAME_TIMEOUT - 1));
    // In WAIT the timer equals (cycles since strobe - 1); a ready exactly
    // IO_TIMEOUT cycles after the strobe still wins over the timeout.
    assign w_io_expired = (state_q == S_WAIT) && !io_ready &&
                          (io_timer_q == IO_TW'(IO_TIMEOUT - 1));
    assign w_send = (state_q == S_RESP) && !guard_q && !tx_busy;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (new_rx_data) begin
                    state_d = w_op_known ? S_ADDR : S_RESP;
                end
            end
            S_ADDR: begin
                if (w_frame_expired) begin
                    state_d = S_IDLE;
                end else if (w_last_addr) begin
                    state_d = is_write_q ? S_DATA : S_ISSUE;
                end
            end
            S_DATA: begin
                if (w_frame_expired) begin
                    state_d = S_IDLE;
                end else if (w_last_data) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (io_ready || w_io_expired) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (w_send && (resp_cnt_q == 3'd1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        tx_data         = 8'h00;
        new_tx_data     = 1'b0;
        busy            = 1'b0;
        case (state_q)
            S_ISSUE: begin
                io_addr_strobe  = 1'b1;
                io_write_strobe = is_write_q;
                io_read_strobe  = !is_write_q;
                busy            = 1'b1;
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            S_RESP: begin
                tx_data     = resp_q[39:32];
                new_tx_data = w_send;
                busy        = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign io_address     = io_address_q;
    assign io_write_data  = io_write_data_q;
    assign io_byte_enable = 4'hF;
    assign drop_count     = drop_q;

    // ------------------------------------------------------------------
    // Datapath: frame assembly, bus registers, timers, reply buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write_q      <= 1'b0;
            byte_cnt_q      <= 2'd0;
            addr_sh_q       <= 32'h0;
            wdata_sh_q      <= 24'h0;
            io_address_q    <= 32'h0;
            io_write_data_q <= 32'h0;
            io_timer_q      <= '0;
            frame_timer_q   <= '0;
            resp_q          <= 40'h0;
            resp_cnt_q      <= 3'd0;
            guard_q         <= 1'b0;
        end else begin
            guard_q <= w_send;
            case (state_q)
                S_IDLE: begin
                    if (new_rx_data) begin
                        byte_cnt_q    <= 2'd0;
                        frame_timer_q <= '0;
                        is_write_q    <= (rx_data == c_OP_WRITE);
                        if (!w_op_known) begin
                            resp_q     <= {c_RSP_BAD, 32'h0};
                            resp_cnt_q <= 3'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (new_rx_data) begin
                        addr_sh_q     <= {addr_sh_q[23:0], rx_data};
                        byte_cnt_q    <= byte_cnt_q + 2'd1;
                        frame_timer_q <= '0;
                        // A read issues straight after the address, so the bus
                        // register is loaded with the completed address here.
                        if (w_last_addr && !is_write_q) begin
                            io_address_q <= {addr_sh_q[23:0], rx_data};
                        end
                    end else begin
                        frame_timer_q <= frame_timer_q + FR_TW'(1);
                    end
                end
                S_DATA: begin
                    if (new_rx_data) begin
                        wdata_sh_q    <= {wdata_sh_q[15:0], rx_data};
                        byte_cnt_q    <= byte_cnt_q + 2'd1;
                        frame_timer_q <= '0;
                        if (w_last_data) begin
                            io_address_q    <= addr_sh_q;
                            io_write_data_q <= {wdata_sh_q, rx_data};
                        end
                    end else begin
                        frame_timer_q <= frame_timer_q + FR_TW'(1);
                    end
                end
                S_ISSUE: begin
                    io_timer_q <= '0;
                end
                S_WAIT: begin
                    io_timer_q <= io_timer_q + IO_TW'(1);
                    if (io_ready) begin
                        if (is_write_q) begin
                            resp_q     <= {c_RSP_OK, 32'h0};
                            resp_cnt_q <= 3'd1;
                        end else begin
                            resp_q     <= {c_RSP_DATA, io_read_data};
                            resp_cnt_q <= 3'd5;
                        end
                    end else if (w_io_expired) begin
                        resp_q     <= {c_RSP_TIMEOUT, 32'h0};
                        resp_cnt_q <= 3'd1;
                    end
                end
                S_RESP: begin
                    if (w_send) begin
                        resp_q     <= {resp_q[31:0], 8'h00};
                        resp_cnt_q <= resp_cnt_q - 3'd1;
                    end
                end
                default: begin
                    io_timer_q <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Overrun counter: bytes arriving while a transaction or reply is active
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'h00;
        end else if (new_rx_data && busy && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'h01;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_io_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_io_master
// Description : Self-checking bench for serial_io_master. Stimulus pushes the
//               expected bus transaction and reply bytes into queues; monitors
//               pop and compare whenever the DUT strobes the bus or pulses tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_io_master;

    localparam int IO_TO = 400;
    localparam int FR_TO = 300;
    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
    } bus_t;

    typedef struct packed {
        logic       tmo;
        logic [7:0] b;
    } txe_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy;
    logic        io_addr_strobe;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [31:0] io_address;
    logic [31:0] io_write_data;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_read_data;
    logic        io_ready;
    logic        busy;
    logic [7:0]  drop_count;

    serial_io_master #(.IO_TIMEOUT(IO_TO), .FRAME_TIMEOUT(FR_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_address(io_address),
        .io_write_data(io_write_data), .io_byte_enable(io_byte_enable),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .busy(busy), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    bus_t exp_bus[$];
    txe_t exp_tx[$];
    int   strobe_cnt = 0;
    int   strobe_cyc = 0;
    bit   tx_pend    = 1'b0;
    bit   hold_valid = 1'b0;
    logic [31:0] hold_addr, hold_wd;
    int   drop_exp   = 0;
    bus_t eb;
    txe_t et;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- bus monitor ----------------
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            hold_valid = 1'b0;
        end else if (io_addr_strobe === 1'b1) begin
            strobe_cnt++;
            strobe_cyc = cyc;
            chk("strobe_expected", 32'(exp_bus.size() != 0), 32'd1);
            if (exp_bus.size() != 0) begin
                eb = exp_bus.pop_front();
                chk("io_write_strobe", 32'(io_write_strobe), 32'(eb.wr));
                chk("io_read_strobe", 32'(io_read_strobe), 32'(!eb.wr));
                chk("io_address", io_address, eb.addr);
                if (eb.wr) chk("io_write_data", io_write_data, eb.wd);
            end
            hold_addr  = io_address;
            hold_wd    = io_write_data;
            hold_valid = 1'b1;
        end else begin
            chk("orphan_strobe", 32'({io_read_strobe, io_write_strobe}), 32'd0);
            if (hold_valid) begin
                chk("addr_hold", io_address, hold_addr);
                chk("wdata_hold", io_write_data, hold_wd);
            end
        end
    end

    // ---------------- tx monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && new_tx_data === 1'b1) begin
            tx_pend = 1'b1;
            chk("tx_busy_at_pulse", 32'(tx_busy), 32'd0);
            chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
            if (exp_tx.size() != 0) begin
                et = exp_tx.pop_front();
                chk("tx_data", 32'(tx_data), 32'(et.b));
                if (et.tmo) chk("timeout_latency", 32'(cyc - strobe_cyc), 32'(IO_TO + 1));
            end
        end
    end

    // ---------------- transmitter model ----------------
    initial begin
        int busy_left;
        busy_left = 0;
        tx_busy   = 1'b0;
        forever begin
            tick();
            if (tx_pend) begin
                tx_pend   = 1'b0;
                busy_left = $urandom_range(0, 4);
            end
            if (busy_left > 0) begin
                tx_busy = 1'b1;
                busy_left--;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data     = b;
        new_rx_data = 1'b1;
        tick();
        new_rx_data = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic push_tx(input logic [7:0] b, input logic tmo);
        txe_t t;
        t.b   = b;
        t.tmo = tmo;
        exp_tx.push_back(t);
    endtask

    task automatic wait_reply();
        for (int i = 0; i < 3000 && exp_tx.size() != 0; i++) tick();
        chk("reply_complete", 32'(exp_tx.size()), 32'd0);
        exp_tx.delete();
    endtask

    task automatic wait_strobe(input int s0, output bit ok);
        for (int i = 0; i < 20 && strobe_cnt == s0; i++) tick();
        ok = (strobe_cnt != s0);
        chk("strobe_seen", 32'(ok), 32'd1);
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    // One command frame. lat = cycles from strobe to io_ready (0 = never);
    // drops = bytes fed during the transaction; gap < 0 means random gaps.
    task automatic run_txn(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int lat, input int drops, input int gap);
        logic [7:0] fb[$];
        bus_t       b;
        bit         ok;
        int         s0, n;
        if (op != OP_W && op != OP_R) begin
            push_tx(8'h3F, 1'b0);
            send_byte(op, 0);
            wait_reply();
            chk("drop_count", 32'(drop_count), 32'(drop_exp));
            return;
        end
        b.wr = (op == OP_W); b.addr = addr; b.wd = wd;
        exp_bus.push_back(b);
        if (lat >= 1 && lat <= IO_TO) begin
            if (b.wr) begin
                push_tx(8'h4B, 1'b0);
            end else begin
                push_tx(8'h44, 1'b0);
                for (int i = 3; i >= 0; i--) push_tx(rd[i*8 +: 8], 1'b0);
            end
        end else begin
            push_tx(8'h54, 1'b1);
        end
        fb.push_back(op);
        for (int i = 3; i >= 0; i--) fb.push_back(addr[i*8 +: 8]);
        if (b.wr) for (int i = 3; i >= 0; i--) fb.push_back(wd[i*8 +: 8]);
        s0 = strobe_cnt;
        for (int i = 0; i < fb.size(); i++)
            send_byte(fb[i], (i == fb.size() - 1) ? 0 : (gap < 0 ? int'($urandom_range(0, 2)) : gap));
        wait_strobe(s0, ok);
        if (!ok) begin
            exp_bus.delete();
            exp_tx.delete();
            return;
        end
        n = (lat > drops) ? lat : drops;
        for (int c = 1; c <= n; c++) begin
            io_ready     = (c == lat);
            io_read_data = (c == lat) ? rd : $urandom;
            rx_data      = 8'($urandom);
            new_rx_data  = (c <= drops);
            tick();
        end
        io_ready    = 1'b0;
        new_rx_data = 1'b0;
        drop_exp    = sat_add(drop_exp, drops);
        wait_reply();
        chk("drop_count", 32'(drop_count), 32'(drop_exp));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr_strobe"}, 32'(io_addr_strobe), 32'd0);
        chk({tag, "_rw_strobe"}, 32'({io_read_strobe, io_write_strobe}), 32'd0);
        chk({tag, "_new_tx"}, 32'(new_tx_data), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_io_address"}, io_address, 32'd0);
        chk({tag, "_io_wdata"}, io_write_data, 32'd0);
        chk({tag, "_byte_en"}, 32'(io_byte_enable), 32'hF);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_drop"}, 32'(drop_count), 32'd0);
    endtask

    task automatic quiet_after_reset(input string tag);
        drop_exp = 0;
        exp_tx.delete();
        exp_bus.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            io_ready = (i % 3 == 0);
            tick();
        end
        io_ready = 1'b0;
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_drop_after"}, 32'(drop_count), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] op;
        int lat, drops, r;
        bit ok;
        int s0;
        rst_n = 1'b0; rx_data = 8'h00; new_rx_data = 1'b0;
        io_ready = 1'b0; io_read_data = 32'h0;
        repeat (3) tick();
        check_reset("por");
        rst_n = 1'b1;
        tick();

        // directed write / read
        run_txn(OP_W, 32'hD100_0005, 32'h0000_00A5, 32'h0, 1, 0, 0);
        run_txn(OP_R, 32'hD000_0004, 32'h0, 32'h0000_002A, 3, 0, 0);
        // overrun of 3 bytes during WAIT
        run_txn(OP_R, 32'hD000_0008, 32'h0, 32'hCAFE_F00D, 10, 3, 1);
        // timeout, then a spurious ready 5 cycles later
        run_txn(OP_R, 32'hD000_000C, 32'h0, 32'h0, 0, 0, 0);
        repeat (4) tick();
        io_ready = 1'b1; tick(); io_ready = 1'b0;
        repeat (10) tick();
        chk("spurious_ready_busy", 32'(busy), 32'd0);
        // latency boundaries
        run_txn(OP_W, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, IO_TO, 0, 0);
        run_txn(OP_R, 32'h0000_0010, 32'h0, 32'h5555_AAAA, IO_TO + 1, 0, 0);
        // bad opcode
        run_txn(8'h00, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        // partial frame abandoned after FR_TO idle cycles
        send_byte(OP_W, 0);
        send_byte(8'hD1, FR_TO);
        chk("partial_frame_busy", 32'(busy), 32'd0);
        run_txn(OP_R, 32'hD000_0004, 32'h0, 32'h1122_3344, 2, 0, 0);
        // longest legal inter-byte gap is still one frame
        run_txn(OP_W, 32'hD100_0000, 32'h0102_0304, 32'h0, 2, 0, FR_TO - 1);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do op = 8'($urandom); while (op == OP_W || op == OP_R);
            end else begin
                op = ($urandom_range(0, 1) == 1) ? OP_W : OP_R;
            end
            r = $urandom_range(0, 9);
            lat = (r == 0) ? 0 : (r == 1) ? IO_TO : int'($urandom_range(1, 6));
            drops = $urandom_range(0, (lat == 0) ? 3 : ((lat < 3) ? lat : 3));
            run_txn(op, $urandom, $urandom, $urandom, lat, drops, -1);
        end

        // saturation of the drop counter
        run_txn(OP_R, 32'hD000_0020, 32'h0, 32'h0, 0, 300, 0);
        chk("drop_saturated", 32'(drop_count), 32'hFF);

        // reset during WAIT
        exp_bus.push_back('{wr: 1'b0, addr: 32'hD000_0030, wd: 32'h0});
        s0 = strobe_cnt;
        send_byte(OP_R, 0); send_byte(8'hD0, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h30, 0);
        wait_strobe(s0, ok);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1 check_reset("rst_wait");
        quiet_after_reset("rst_wait");

        // reset during RESP
        exp_bus.push_back('{wr: 1'b0, addr: 32'hD000_0040, wd: 32'h0});
        push_tx(8'h44, 1'b0);
        for (int i = 0; i < 4; i++) push_tx(8'h77, 1'b0);
        s0 = strobe_cnt;
        send_byte(OP_R, 0); send_byte(8'hD0, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h40, 0);
        wait_strobe(s0, ok);
        io_ready = 1'b1; io_read_data = 32'h7777_7777; tick(); io_ready = 1'b0;
        for (int i = 0; i < 50 && exp_tx.size() > 4; i++) tick();
        chk("first_reply_byte_sent", 32'(exp_tx.size()), 32'd4);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_resp");
        quiet_after_reset("rst_resp");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
